// File: rtl/mem_fill_responder.sv
// mem_fill_responder: word memory with a fixed-latency, stall-free read pipeline.
// Reads sample the array at the accepting edge and ride a {valid, data} shift
// pipeline to the output. Writes update the array and produce no response.
module mem_fill_responder #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int INDEX_BITS = 13,
    parameter int LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  wr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic [3:0]            pending
);
    localparam int DEPTH  = 1 << INDEX_BITS;
    localparam int STAGES = LATENCY - 1;

    typedef struct packed {
        logic                  en;
        logic                  wr;
        logic [INDEX_BITS-1:0] idx;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    req_t                             req;
    logic                             rd_acc;
    logic [DATA_WIDTH-1:0]            mem [DEPTH];
    logic [STAGES:0]                  vld_pipe;
    logic [STAGES:0][DATA_WIDTH-1:0]  dat_pipe;
    logic [3:0]                       pend_q;

    // Byte address -> word index; addr[0] and bits above the index alias away.
    assign req    = '{en: enable, wr: wr, idx: addr[INDEX_BITS:1], wdata: data_in};
    assign rd_acc = req.en & ~req.wr;

    if (ADDR_WIDTH > INDEX_BITS + 1) begin : g_hi_addr
        logic unused_addr;
        assign unused_addr = ^{addr[0], addr[ADDR_WIDTH-1:INDEX_BITS+1]};
    end else begin : g_no_hi_addr
        logic unused_addr;
        assign unused_addr = addr[0];
    end

    // Array write port; contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (req.en && req.wr)
            mem[req.idx] <= req.wdata;
    end

    // Read pipeline: stage 0 samples the array, later stages shift forward.
    // Data only advances behind a valid bit, so the last stage holds the most
    // recently returned word between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe[0] <= rd_acc;
            if (rd_acc)
                dat_pipe[0] <= mem[req.idx];
            for (int k = 1; k <= STAGES; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                if (vld_pipe[k-1])
                    dat_pipe[k] <= dat_pipe[k-1];
            end
        end
    end

    // In-flight read count; an accept and a return in one cycle cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            case ({rd_acc, vld_pipe[STAGES]})
                2'b10:   pend_q <= pend_q + 4'd1;
                2'b01:   pend_q <= pend_q - 4'd1;
                default: pend_q <= pend_q;
            endcase
        end
    end

    assign data_valid = vld_pipe[STAGES];
    assign data_out   = dat_pipe[STAGES];
    assign pending    = pend_q;

endmodule

// File: tb/tb_mem_fill_responder.sv
// tb_mem_fill_responder: drives one request stream into three responders
// (LATENCY 1, 4, 8) and checks every cycle against a history-based model:
// a read issued in cycle i returns the word as written before cycle i,
// exactly L cycles later; pending counts reads issued in the last L cycles.
module tb_mem_fill_responder;
    localparam int MAXC  = 4096;
    localparam int DEPTH = 8192;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        wr = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] data_in = '0;
    logic [15:0] dout [3];
    logic        dv   [3];
    logic [3:0]  pend [3];

    always #5 clk = ~clk;

    mem_fill_responder #(.LATENCY(1)) u_l1 (.clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr),
        .addr(addr), .data_in(data_in), .data_out(dout[0]), .data_valid(dv[0]), .pending(pend[0]));
    mem_fill_responder #(.LATENCY(4)) u_l4 (.clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr),
        .addr(addr), .data_in(data_in), .data_out(dout[1]), .data_valid(dv[1]), .pending(pend[1]));
    mem_fill_responder #(.LATENCY(8)) u_l8 (.clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr),
        .addr(addr), .data_in(data_in), .data_out(dout[2]), .data_valid(dv[2]), .pending(pend[2]));

    int          n_chk = 0;
    int          n_fail = 0;
    int          t = 0;
    bit          is_rd    [MAXC];
    bit          rd_known [MAXC];
    logic [15:0] rd_dat   [MAXC];
    logic [15:0] mmem [int];

    function automatic int lat(int d);
        return (d == 0) ? 1 : (d == 1) ? 4 : 8;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", tag, t, obs, exp);
        end
    endtask

    // Compare the outputs of the current cycle against the issue history.
    task automatic check_cycle();
        for (int d = 0; d < 3; d++) begin
            int L = lat(d);
            if (!rst_n) begin
                chk($sformatf("rst_valid_L%0d", L), 32'(dv[d]), 32'd0);
                chk($sformatf("rst_pend_L%0d", L), 32'(pend[d]), 32'd0);
                chk($sformatf("rst_dout_L%0d", L), 32'(dout[d]), 32'd0);
            end else begin
                bit exp_v = (t >= L) && is_rd[t-L];
                int np = 0;
                for (int i = t - L; i < t; i++)
                    if (i >= 0 && is_rd[i]) np++;
                chk($sformatf("valid_L%0d", L), 32'(dv[d]), 32'(exp_v));
                chk($sformatf("pend_L%0d", L), 32'(pend[d]), 32'(np));
                if (exp_v && rd_known[t-L])
                    chk($sformatf("data_L%0d", L), 32'(dout[d]), 32'(rd_dat[t-L]));
            end
        end
    endtask

    // One cycle: check outputs, then present this cycle's request (or reset).
    task automatic step(bit rst, bit en, bit w, logic [15:0] a, logic [15:0] d);
        int key;
        @(negedge clk);
        check_cycle();
        key = (int'(a) / 2) % DEPTH;
        if (rst) begin
            rst_n  = 1'b0;
            enable = 1'b0;
            wr     = 1'b0;
            for (int i = 0; i < MAXC; i++) is_rd[i] = 1'b0;
        end else begin
            rst_n   = 1'b1;
            enable  = en;
            wr      = w;
            addr    = a;
            data_in = d;
            is_rd[t] = en && !w;
            if (en && !w) begin
                rd_known[t] = mmem.exists(key);
                rd_dat[t]   = rd_known[t] ? mmem[key] : 16'h0;
            end
            if (en && w)
                mmem[key] = d;
        end
        t++;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 16'h0, 16'h0);
    endtask

    initial begin
        // reset state
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        idle(2);

        // single read after a write
        step(0, 1, 1, 16'h0010, 16'hBEEF);
        idle(2);
        step(0, 1, 0, 16'h0010, 16'h0);
        idle(9);

        // preload then 8 back-to-back reads
        for (int i = 0; i < 8; i++) step(0, 1, 1, 16'(16'h1000 + 2*i), 16'(16'hA0 + i));
        for (int i = 0; i < 8; i++) step(0, 1, 0, 16'(16'h1000 + 2*i), 16'h0);
        idle(10);

        // odd and aliased addresses
        step(0, 1, 1, 16'h0020, 16'h1234);
        step(0, 1, 0, 16'h0021, 16'h0);
        step(0, 1, 1, 16'h4020, 16'h5555);
        step(0, 1, 0, 16'h0020, 16'h0);
        idle(9);

        // read / write / read hazard, then write-then-read
        step(0, 1, 1, 16'h0300, 16'h1111);
        idle(1);
        step(0, 1, 0, 16'h0300, 16'h0);
        step(0, 1, 1, 16'h0300, 16'h7777);
        step(0, 1, 0, 16'h0300, 16'h0);
        step(0, 1, 1, 16'h0302, 16'h2222);
        step(0, 1, 0, 16'h0302, 16'h0);
        idle(9);

        // reset while reads are in flight
        for (int i = 0; i < 3; i++) step(0, 1, 0, 16'(16'h1000 + 2*i), 16'h0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        idle(1);
        step(0, 1, 0, 16'h1004, 16'h0);
        idle(10);

        // mixed stream: read, idle, write, read, read
        step(0, 1, 0, 16'h1002, 16'h0);
        idle(1);
        step(0, 1, 1, 16'h1002, 16'h3C3C);
        step(0, 1, 0, 16'h1002, 16'h0);
        step(0, 1, 0, 16'h1006, 16'h0);
        idle(10);

        // randomized stream over a small aliasing address pool
        for (int i = 0; i < 16; i++) step(0, 1, 1, 16'(16'h0400 + 2*i), 16'($urandom));
        for (int i = 0; i < 600; i++) begin
            int r = $urandom_range(0, 99);
            logic [15:0] a;
            a = 16'(16'h0400 + 2*$urandom_range(0, 15) + $urandom_range(0, 1)
                    + ($urandom_range(0, 3) << 14));
            if (r < 2)       step(1, 0, 0, 0, 0);
            else if (r < 20) step(0, 0, 0, 0, 0);
            else if (r < 45) step(0, 1, 1, a, 16'($urandom));
            else             step(0, 1, 0, a, 16'h0);
        end
        idle(10);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
